// File: rtl/memoutsel_pkg.sv
// Shared constants and the modulo bank-pointer increment for the N-bank output selector.
package memoutsel_pkg;

    localparam int MEMOUTSEL_MAX_BANKS = 16;
    localparam int DROP_CNT_W          = 16;
    localparam int PTR_MAX_W           = $clog2(MEMOUTSEL_MAX_BANKS);

    // Wraps to 0 after the last bank so non-power-of-2 bank counts work.
    function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] p,
                                                     input int num_banks);
        return (int'(p) == num_banks - 1) ? '0 : p + PTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/memoutsel_bank_ctrl.sv
// Circular bank queue control: write/read pointers, fill count, ready/valid,
// one-hot write gate and sticky overflow/underflow flags.
module memoutsel_bank_ctrl
    import memoutsel_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iWR_DONE,
    input  logic                 iRD_DONE,
    output logic [NUM_BANKS-1:0] oWR_SEL,
    output logic                 oWR_READY,
    output logic [BANK_W-1:0]    oRD_BANK,
    output logic                 oRD_VALID,
    output logic                 oOVF,
    output logic                 oUNF,
    output logic                 oWR_REJ
);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    logic [BANK_W-1:0] r_wr_ptr;
    logic [BANK_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_unf;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Acceptance uses the pre-edge count, so a read never frees room for a same-cycle write.
    assign oWR_READY = (r_cnt < CNT_W'(NUM_BANKS));
    assign oRD_VALID = (r_cnt != '0);
    assign w_wr_acc  = iWR_DONE && oWR_READY;
    assign w_rd_acc  = iRD_DONE && oRD_VALID;
    assign oWR_REJ   = iWR_DONE && !oWR_READY;
    assign oRD_BANK  = r_rd_ptr;
    assign oOVF      = r_ovf;
    assign oUNF      = r_unf;

    always_comb begin
        oWR_SEL = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            oWR_SEL[k] = oWR_READY && (r_wr_ptr == BANK_W'(k));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= BANK_W'(ptr_inc(PTR_MAX_W'(r_wr_ptr), NUM_BANKS));
            if (w_rd_acc)
                r_rd_ptr <= BANK_W'(ptr_inc(PTR_MAX_W'(r_rd_ptr), NUM_BANKS));
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (oWR_REJ)
                r_ovf <= 1'b1;
            if (iRD_DONE && !oRD_VALID)
                r_unf <= 1'b1;
        end
    end

endmodule

// File: rtl/memoutsel_nbank.sv
// N-bank memory output selector: bank queue control plus registered read-data mux.
// Optional MEMOUTSEL_DROP_CNT_EN adds a saturating count of rejected writes (oDROP_CNT).
module memoutsel_nbank
    import memoutsel_pkg::*;
#(
    parameter int DATA_WIDTH = 640,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] iMEMOUT,
    input  logic                            iWR_DONE,
    input  logic                            iRD_DONE,
    output logic [NUM_BANKS-1:0]            oWR_SEL,
    output logic                            oWR_READY,
    output logic [BANK_W-1:0]               oRD_BANK,
    output logic                            oRD_VALID,
    output logic [DATA_WIDTH-1:0]           oMEMOUT_0X,
    output logic                            oOVF,
    output logic                            oUNF
`ifdef MEMOUTSEL_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]           oDROP_CNT
`endif
);
    logic [DATA_WIDTH-1:0] r_memout;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_wr_rej;

    memoutsel_bank_ctrl #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_ctrl (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iWR_DONE  (iWR_DONE),
        .iRD_DONE  (iRD_DONE),
        .oWR_SEL   (oWR_SEL),
        .oWR_READY (oWR_READY),
        .oRD_BANK  (oRD_BANK),
        .oRD_VALID (oRD_VALID),
        .oOVF      (oOVF),
        .oUNF      (oUNF),
        .oWR_REJ   (w_wr_rej)
    );

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            if (oRD_BANK == BANK_W'(k))
                w_rd_data = iMEMOUT[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Sampled every cycle regardless of oRD_VALID; one cycle behind an rd_ptr change.
    always_ff @(posedge iCLK) begin
        if (iRST)
            r_memout <= '0;
        else
            r_memout <= w_rd_data;
    end

    assign oMEMOUT_0X = r_memout;

`ifdef MEMOUTSEL_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST)
            r_drop_cnt <= '0;
        else if (w_wr_rej && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end

    assign oDROP_CNT = r_drop_cnt;
`else
    logic w_unused_rej;
    assign w_unused_rej = w_wr_rej;
`endif

endmodule

// File: tb/tb_memoutsel_nbank.sv
// Scoreboard bench for memoutsel_nbank (3 banks x 8 bits): directed plan plus random traffic.
module tb_memoutsel_nbank;
    localparam int N  = 3;
    localparam int DW = 8;

    logic            iCLK = 1'b0;
    logic            iRST = 1'b1;
    logic [N*DW-1:0] iMEMOUT = '0;
    logic            iWR_DONE = 1'b0;
    logic            iRD_DONE = 1'b0;
    logic [N-1:0]    oWR_SEL;
    logic            oWR_READY;
    logic [1:0]      oRD_BANK;
    logic            oRD_VALID;
    logic [DW-1:0]   oMEMOUT_0X;
    logic            oOVF;
    logic            oUNF;
`ifdef MEMOUTSEL_DROP_CNT_EN
    logic [15:0]     oDROP_CNT;
`endif

    memoutsel_nbank #(.DATA_WIDTH(DW), .NUM_BANKS(N)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iMEMOUT    (iMEMOUT),
        .iWR_DONE   (iWR_DONE),
        .iRD_DONE   (iRD_DONE),
        .oWR_SEL    (oWR_SEL),
        .oWR_READY  (oWR_READY),
        .oRD_BANK   (oRD_BANK),
        .oRD_VALID  (oRD_VALID),
        .oMEMOUT_0X (oMEMOUT_0X),
        .oOVF       (oOVF),
        .oUNF       (oUNF)
`ifdef MEMOUTSEL_DROP_CNT_EN
        ,
        .oDROP_CNT  (oDROP_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [N-1:0]  sel;
        logic          ready;
        logic [1:0]    bank;
        logic          valid;
        logic [DW-1:0] data;
        logic          ovf;
        logic          unf;
        logic [15:0]   drop;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: running totals of accepted writes/reads; banks are totals mod N.
    int            m_wr = 0;
    int            m_rd = 0;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    int            m_drop = 0;
    logic [DW-1:0] m_data = '0;

    task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [N*DW-1:0] mem);
        exp_t e;
        int   fill;
        @(negedge iCLK);
        iRST = rst; iWR_DONE = wr; iRD_DONE = rd; iMEMOUT = mem;
        fill = m_wr - m_rd;
        if (rst) begin
            m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0; m_drop = 0; m_data = '0;
        end else begin
            m_data = DW'(mem >> (DW * (m_rd % N)));
            if (wr) begin
                if (fill < N) m_wr++;
                else begin m_ovf = 1; if (m_drop < 16'hFFFF) m_drop++; end
            end
            if (rd) begin
                if (fill > 0) m_rd++;
                else m_unf = 1;
            end
        end
        fill    = m_wr - m_rd;
        e.ready = (fill < N);
        e.sel   = e.ready ? N'(1 << (m_wr % N)) : '0;
        e.bank  = 2'(m_rd % N);
        e.valid = (fill != 0);
        e.data  = m_data;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.drop  = 16'(m_drop);
        q.push_back(e);
    endtask

    always @(posedge iCLK) begin
        exp_t e;
        logic [15:0] drop_act;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
`ifdef MEMOUTSEL_DROP_CNT_EN
            drop_act = oDROP_CNT;
`else
            drop_act = e.drop;
`endif
            n_chk++;
            if (oWR_SEL === e.sel && oWR_READY === e.ready && oRD_BANK === e.bank &&
                oRD_VALID === e.valid && oMEMOUT_0X === e.data && oOVF === e.ovf &&
                oUNF === e.unf && drop_act === e.drop)
                n_pass++;
            else
                $display("FAIL outputs @%0t: got sel=%b rdy=%b bank=%0d vld=%b data=%h ovf=%b unf=%b drop=%0d, want sel=%b rdy=%b bank=%0d vld=%b data=%h ovf=%b unf=%b drop=%0d",
                         $time, oWR_SEL, oWR_READY, oRD_BANK, oRD_VALID, oMEMOUT_0X, oOVF, oUNF, drop_act,
                         e.sel, e.ready, e.bank, e.valid, e.data, e.ovf, e.unf, e.drop);
        end
    end

    initial begin
        logic [N*DW-1:0] mem;
        mem = {8'h33, 8'h22, 8'h11};
        // Reset, idle, fill to full, overflow, write+read at full.
        cyc(1, 0, 0, mem); cyc(1, 0, 0, mem);
        cyc(0, 0, 0, mem); cyc(0, 0, 0, mem);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, mem);
        cyc(0, 1, 0, mem);
        cyc(0, 1, 1, mem);
        cyc(0, 1, 0, mem);
        // Drain in FIFO order, one release every 4 cycles, past empty into underflow.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, mem);
            for (int j = 0; j < 3; j++) cyc(0, 0, 0, mem);
        end
        cyc(0, 0, 1, mem);
        // Simultaneous accept at cnt=1, then mid-operation reset at cnt=2 with both pulses.
        cyc(0, 1, 0, mem); cyc(0, 1, 1, mem); cyc(0, 0, 0, mem);
        cyc(0, 1, 0, mem); cyc(1, 1, 1, mem); cyc(0, 0, 0, mem);
        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            mem = N*DW'({$urandom, $urandom});
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1), mem);
        end
        @(negedge iCLK);
        iWR_DONE = 1'b0; iRD_DONE = 1'b0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge iCLK);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memoutsel_nbank.md
Name: memoutsel_nbank

Overview:
- N-bank successor to the two-bank A/B memory output selector.
- Manages NUM_BANKS line/frame memories as a circular bank queue:
  - writer fills banks in order;
  - reader consumes completed banks in FIFO order.
- Selected bank's read data is presented on a registered output.
- Sits between the per-bank line memories and the downstream eye-feature processing stage.

Parameters:
- DATA_WIDTH, 640, width of one bank's read data word.
- NUM_BANKS, 2, number of banks; legal range 2..16; non-power-of-2 supported.
- BANK_W, $clog2(NUM_BANKS), bank index width; derived, not overridden.

Ports:
- iCLK  input  1  clock.
- iRST  input  1  reset; synchronous, active-high.
- iMEMOUT  input  NUM_BANKS*DATA_WIDTH  concatenated bank read data; bank k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- iWR_DONE  input  1  one-cycle pulse: writer finished filling the current write bank.
- iRD_DONE  input  1  one-cycle pulse: reader finished with the current read bank.
- oWR_SEL  output  NUM_BANKS  one-hot write-enable gate for the current write bank.
- oWR_READY  output  1  a free bank is available for writing.
- oRD_BANK  output  BANK_W  current read bank index.
- oRD_VALID  output  1  at least one completed bank is available.
- oMEMOUT_0X  output  DATA_WIDTH  registered read data of the selected bank.
- oOVF  output  1  sticky: iWR_DONE arrived while oWR_READY=0.
- oUNF  output  1  sticky: iRD_DONE arrived while oRD_VALID=0.

Behaviour:
- State:
  - wr_ptr, rd_ptr: BANK_W bits each.
  - cnt: $clog2(NUM_BANKS+1) bits; number of completed, unread banks.
- Reset (iRST=1 at a rising edge; overrides all other inputs, including mid-operation):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - oMEMOUT_0X=0, oOVF=0, oUNF=0.
  - Therefore oWR_SEL=1 (bank 0), oWR_READY=1, oRD_VALID=0, oRD_BANK=0.
- Derived outputs (decoded from registered state only; no input-to-output combinational path):
  - oWR_READY = (cnt < NUM_BANKS).
  - oRD_VALID = (cnt != 0).
  - oRD_BANK = rd_ptr.
  - oWR_SEL = onehot(wr_ptr) when oWR_READY, else all zero.
- Write accept: iWR_DONE && oWR_READY → wr_ptr advances, cnt+1.
- Write reject: iWR_DONE && !oWR_READY → no state change, oOVF<=1.
- Read release: iRD_DONE && oRD_VALID → rd_ptr advances, cnt-1.
- Read reject: iRD_DONE && !oRD_VALID → no state change, oUNF<=1.
- Simultaneous accepted write and read: both pointers advance, cnt unchanged.
- Acceptance is judged on the pre-edge cnt. At cnt==NUM_BANKS, a simultaneous iRD_DONE does not rescue iWR_DONE: the write is rejected, oOVF=1, and the read is released.
- Pointer advance: p <= (p==NUM_BANKS-1) ? 0 : p+1.
- Data path:
  - oMEMOUT_0X <= iMEMOUT slice[rd_ptr] every cycle, regardless of oRD_VALID.
  - Latency 1 cycle: data at edge t+1 reflects iMEMOUT and rd_ptr at edge t.
  - After an rd_ptr advance, the first cycle of output still shows the old bank; the consumer must discard that one cycle.
- oOVF and oUNF clear only on iRST.
- With NUM_BANKS=2 and cnt toggling 0↔1, this behaves as classic ping-pong.

Optional Feature:
- Macro: MEMOUTSEL_DROP_CNT_EN.
- Defined:
  - Adds output port oDROP_CNT (16 bits), reset 0.
  - Increments by 1 on every rejected iWR_DONE; saturates at 16'hFFFF.
  - oOVF behaviour is unchanged.
- Undefined: port absent, no counter logic; everything else identical.

Decomposition:
- Package memoutsel_pkg holds:
  - MEMOUTSEL_MAX_BANKS = 16;
  - the DROP_CNT_W = 16 constant;
  - a ptr_inc function implementing modulo-NUM_BANKS increment.
- One sub-module, memoutsel_bank_ctrl: pointers, cnt, ready/valid, one-hot decode, sticky flags.
- Top level: data mux register plus the optional drop counter.

Test Plan:
- Reset/idle (NUM_BANKS=3, DATA_WIDTH=8), iMEMOUT={8'h33,8'h22,8'h11}, release iRST → oWR_SEL=3'b001, oWR_READY=1, oRD_VALID=0; next cycle oMEMOUT_0X=8'h11.
- Fill to full: 3 iWR_DONE pulses → cnt 1,2,3; oWR_SEL 010,100,000; oWR_READY=0 after 3rd; wr_ptr wraps to 0.
- Overflow (build with MEMOUTSEL_DROP_CNT_EN): 4th iWR_DONE while full → oOVF=1, oDROP_CNT=1, pointers unchanged; iWR_DONE and iRD_DONE in the same cycle at full → write rejected, oDROP_CNT=2, cnt=2.
- Drain order: from full, iRD_DONE each 4 cycles → oRD_BANK 0,1,2,0 follows FIFO order; oMEMOUT_0X equals the matching bank byte one cycle after each change; oRD_VALID=0 at empty.
- Underflow and simultaneous: iRD_DONE at cnt=0 → oUNF=1, rd_ptr held; at cnt=1, iWR_DONE+iRD_DONE together → cnt stays 1, both pointers +1.
- Mid-operation reset: assert iRST at cnt=2 with both pulses high → all state and outputs return to reset values on that edge.
